invaders_rom_loader: RTL and testbench
======================================

# invaders_rom_loader

Download-side write sequencer for the arcade memory block: turns the framework's ROM download byte stream into the single-cycle `dn_addr`/`dn_data`/`dn_wr` write bus consumed by the program ROMs (`0000-3FFF`) and colour PROM (`4000-47FF`). Before accepting stream data, it zero-fills the colour PROM so that games without a colour PROM never show stale colours. Incoming bytes are buffered and back-pressured while the fill runs. The block reports completion and errors to the top level, which holds the CPU in reset until `load_done`.

## Interface
- `FIFO_DEPTH`, 4: byte buffer entries, power of two, ≥4.
- `CLEAR_BASE`, 16'h4000: first colour PROM address zero-filled.
- `CLEAR_WORDS`, 2048: number of zero-fill writes.
- `Clock`  in  1  system clock; the block's only clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_download`  in  1  download window active.
- `ioctl_index`  in  8  stream index; only 8'h00 is loaded.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `ioctl_addr`  in  25  byte offset within the stream.
- `ioctl_dout`  in  8  stream byte.
- `ioctl_wait`  out  1  back-pressure to the source.
- `mod_cosmo`  in  1  colour RAM is CPU-written; stream bytes `4000-47FF` are dropped.
- `dn_addr`  out  16  write address.
- `dn_data`  out  8  write data.
- `dn_wr`  out  1  one-cycle write strobe.
- `load_busy`  out  1  sequencer not in IDLE/DONE.
- `load_done`  out  1  load complete; held until the next download starts.
- `load_err`  out  1  sticky: FIFO overrun or address ≥ 16'h4800.
- `load_sum`  out  16  byte checksum (see Configuration).
- `load_len`  out  16  count of bytes written from the stream.

## Operation
- Reset values: all outputs 0; state IDLE; FIFO empty; counters 0.
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE/DONE → CLEAR on a rising edge of `ioctl_download` while `ioctl_index`==0. This clears `load_done`, `load_err`, `load_sum`, `load_len` and `clr_cnt`.
- A rising edge with a nonzero index is ignored; the state is unchanged.
- CLEAR:
  - Every cycle: `dn_wr`=1, `dn_addr`=`CLEAR_BASE`+`clr_cnt`, `dn_data`=0; `clr_cnt` increments.
  - After the write with `clr_cnt`==`CLEAR_WORDS`-1: go to STREAM if `ioctl_download` is still high, else DRAIN.
  - Stream bytes are pushed into the FIFO and are not popped.
- STREAM:
  - Pop one entry per cycle when the FIFO is non-empty and drive `dn_wr`/`dn_addr`=`ioctl_addr[15:0]`/`dn_data`.
  - Entries with `ioctl_addr` ≥ 16'h4800 are popped without a write and set `load_err`.
  - With `mod_cosmo`=1, entries in `4000-47FF` are popped without a write and without an error.
  - Every written entry increments `load_len` and adds the byte to `load_sum` (mod 2^16).
  - On the falling edge of `ioctl_download`, go to DRAIN.
- DRAIN: pop as in STREAM; when the FIFO is empty, go to DONE and set `load_done`=1.
- FIFO push: `ioctl_wr` while `ioctl_download`=1 and the FIFO is not full. `ioctl_wr` with a full FIFO drops the byte and sets `load_err`.
- `ioctl_wait` = registered (FIFO count ≥ `FIFO_DEPTH`-2). The source may issue at most one more strobe after seeing it.
- A push and a pop in the same cycle leave the count unchanged.
- `load_busy`=1 in CLEAR, STREAM and DRAIN.
- A new rising edge of `ioctl_download` during CLEAR, STREAM or DRAIN is ignored.

## Timing
- Each zero-fill takes 1 cycle; the full fill is exactly `CLEAR_WORDS` cycles of contiguous `dn_wr`.
- Stream latency with an empty FIFO in STREAM: `ioctl_wr` sampled at edge N → `dn_wr` high during the cycle after edge N+1 (2 clocks).
- All `dn_*` outputs are registered; `dn_wr` is never high for two cycles on the same stream entry.
- `ioctl_wait` rises the cycle after the count reaches `FIFO_DEPTH`-2 and falls the cycle after it drops below that.
- `load_done` rises on the cycle after the last pop in DRAIN.
- Asserting `Reset_n` low mid-operation immediately forces all outputs to 0 and flushes the FIFO; no partial write strobe is emitted.

## Configuration
- `LOADER_CHECKSUM_EN` defined: `load_sum` and `load_len` are accumulated as described.
- `LOADER_CHECKSUM_EN` undefined: both outputs are tied to 0, with no adder or counter logic. All other behaviour is identical.

## Test plan
- Zero-fill: reset, raise download with index 0, no strobes → exactly 2048 `dn_wr` at `4000..47FF` with data 00; then drop download → `load_done`=1, `load_len`=0.
- Stream through fill: strobes `ioctl_addr`=0,1,2 with data A5,5A,FF spaced 1 cycle apart, starting in cycle 1 of CLEAR → `ioctl_wait`=1 after the 2nd byte. After the fill, writes at 0000/0001/0002 = A5/5A/FF. `load_sum`=16'h01FE, `load_len`=3.
- Overrun: 5 back-to-back strobes during CLEAR, ignoring `ioctl_wait` → 4 bytes written afterwards; `load_err`=1.
- Range/cosmo: byte at 16'h4800 → no write, `load_err`=1. With `mod_cosmo`=1, byte at 16'h4400 → no write, `load_err`=0.
- Latency: in STREAM with an empty FIFO, a strobe at edge N with addr 16'h2000, data 3C → `dn_wr`=1, `dn_addr`=2000, `dn_data`=3C in the cycle after edge N+1.
- Reset mid-CLEAR at `clr_cnt`=100 → `dn_wr`=0 immediately, state IDLE; a new download restarts the fill at 4000.

Source files
------------

// File: rtl/invaders_rom_loader.sv
// ROM download sequencer: zero-fills the colour PROM, then writes stream bytes.
// Optional LOADER_CHECKSUM_EN enables the load_sum/load_len accumulators.
module invaders_rom_loader #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] CLEAR_BASE  = 16'h4000,
    parameter int          CLEAR_WORDS = 2048
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        mod_cosmo,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] load_sum,
    output logic [15:0] load_len
);

    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] WAIT_C = (AW+1)'(FIFO_DEPTH - 2);
    localparam logic [15:0] LAST_C = 16'(CLEAR_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic        hi;
        logic [15:0] addr;
        logic [7:0]  data;
    } entry_t;

    state_t        state;
    logic          dl_q;
    logic [15:0]   clr_cnt;
    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    entry_t        head;

    logic rise;
    logic fall;
    logic start;
    logic accepting;
    logic full;
    logic empty;
    logic push;
    logic overrun;
    logic pop;
    logic pop_bad;
    logic pop_drop;
    logic pop_write;

    assign rise      = ioctl_download & ~dl_q;
    assign fall      = ~ioctl_download & dl_q;
    assign start     = rise & (ioctl_index == 8'h00) &
                       (state == S_IDLE || state == S_DONE);
    assign accepting = ioctl_download &
                       (state == S_CLEAR || state == S_STREAM);
    assign full      = (count == FULL_C);
    assign empty     = (count == '0);
    assign push      = accepting & ioctl_wr & ~full;
    assign overrun   = accepting & ioctl_wr & full;
    assign pop       = (state == S_STREAM || state == S_DRAIN) & ~empty;
    assign head      = mem[rd_ptr];

    // Anything above the colour PROM (including upper stream bits) is bad.
    assign pop_bad   = head.hi | (head.addr >= 16'h4800);
    assign pop_drop  = mod_cosmo & (head.addr >= 16'h4000) & ~pop_bad;
    assign pop_write = pop & ~pop_bad & ~pop_drop;

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= '{hi:   |ioctl_addr[24:16],
                             addr: ioctl_addr[15:0],
                             data: ioctl_dout};
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
            ioctl_wait <= (count >= WAIT_C);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            dl_q      <= 1'b0;
            clr_cnt   <= '0;
            dn_addr   <= '0;
            dn_data   <= '0;
            dn_wr     <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            dl_q  <= ioctl_download;
            dn_wr <= 1'b0;
            if (overrun || (pop && pop_bad)) begin
                load_err <= 1'b1;
            end
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_CLEAR;
                        clr_cnt   <= '0;
                        load_busy <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    dn_wr   <= 1'b1;
                    dn_addr <= CLEAR_BASE + clr_cnt;
                    dn_data <= 8'h00;
                    clr_cnt <= clr_cnt + 16'd1;
                    if (clr_cnt == LAST_C) begin
                        state <= ioctl_download ? S_STREAM : S_DRAIN;
                    end
                end
                S_STREAM: begin
                    if (fall) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (empty) begin
                        state     <= S_DONE;
                        load_busy <= 1'b0;
                        load_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (pop_write) begin
                dn_wr   <= 1'b1;
                dn_addr <= head.addr;
                dn_data <= head.data;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            load_sum <= '0;
            load_len <= '0;
        end else if (start) begin
            load_sum <= '0;
            load_len <= '0;
        end else if (pop_write) begin
            load_sum <= load_sum + {8'h00, head.data};
            load_len <= load_len + 16'd1;
        end
    end
`else
    assign load_sum = '0;
    assign load_len = '0;
`endif

endmodule

// File: tb/tb_invaders_rom_loader.sv
// Bench for invaders_rom_loader: write scoreboard plus table of stream vectors.
module tb_invaders_rom_loader;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic        mod_cosmo = 1'b0;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        load_busy;
    logic        load_done;
    logic        load_err;
    logic [15:0] load_sum;
    logic [15:0] load_len;

    invaders_rom_loader dut (
        .Clock          (clk),
        .Reset_n        (Reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mod_cosmo      (mod_cosmo),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .load_busy      (load_busy),
        .load_done      (load_done),
        .load_err       (load_err),
        .load_sum       (load_sum),
        .load_len       (load_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        cosmo;
        logic        wr;
        logic        err;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vt[6];
    int   nvec = 0;
    int   nerr = 0;

    always @(negedge clk) begin
        if (Reset_n && dn_wr) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_write: got %h/%h want none",
                         dn_addr, dn_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({dn_addr, dn_data} !== {e.addr, e.data}) begin
                    nerr++;
                    $display("FAIL write: got %h/%h want %h/%h",
                             dn_addr, dn_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ck(input logic [15:0] v);
`ifdef LOADER_CHECKSUM_EN
        return v;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic do_reset();
        Reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = '0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        mod_cosmo      = 1'b0;
        exp_q.delete();
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic push_clear(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: 16'h4000 + 16'(i), data: 8'h00});
        end
    endtask

    // Returns in cycle 1 of CLEAR.
    task automatic start_dl();
        tick();
        ioctl_download = 1'b1;
        ioctl_index    = 8'h00;
        tick();
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        tick();
        tick();
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (load_done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("load_done", {31'b0, load_done}, 1);
        check("load_busy_done", {31'b0, load_busy}, 0);
    endtask

    initial begin
        vt[0] = '{25'h04400, 8'h66, 1'b1, 1'b0, 1'b0};
        vt[1] = '{25'h04400, 8'h67, 1'b0, 1'b1, 1'b0};
        vt[2] = '{25'h047FF, 8'h12, 1'b0, 1'b1, 1'b0};
        vt[3] = '{25'h03FFF, 8'h34, 1'b1, 1'b1, 1'b0};
        vt[4] = '{25'h04800, 8'h77, 1'b0, 1'b0, 1'b1};
        vt[5] = '{25'h10000, 8'h55, 1'b0, 1'b0, 1'b1};

        // Reset state and plain zero-fill
        do_reset();
        check("rst_dn_wr", {31'b0, dn_wr}, 0);
        check("rst_dn_addr", {16'b0, dn_addr}, 0);
        check("rst_dn_data", {24'b0, dn_data}, 0);
        check("rst_wait", {31'b0, ioctl_wait}, 0);
        check("rst_busy", {31'b0, load_busy}, 0);
        check("rst_done", {31'b0, load_done}, 0);
        check("rst_err", {31'b0, load_err}, 0);
        check("rst_sum", {16'b0, load_sum}, 0);
        check("rst_len", {16'b0, load_len}, 0);

        ioctl_download = 1'b1;
        ioctl_index    = 8'h05;
        repeat (4) tick();
        check("nz_index_busy", {31'b0, load_busy}, 0);
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        tick();

        push_clear(2048);
        start_dl();
        check("clear_busy", {31'b0, load_busy}, 1);
        wait_drain(3000);
        check("fill_wait", {31'b0, ioctl_wait}, 0);
        ioctl_download = 1'b0;
        wait_done(20);
        check("fill_len", {16'b0, load_len}, 0);
        check("fill_err", {31'b0, load_err}, 0);

        ioctl_download = 1'b1;
        ioctl_index    = 8'h03;
        repeat (3) tick();
        check("nz_done_held", {31'b0, load_done}, 1);
        check("nz_done_busy", {31'b0, load_busy}, 0);
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;

        // Stream bytes buffered during the fill
        do_reset();
        push_clear(2048);
        exp_q.push_back('{16'h0000, 8'hA5});
        exp_q.push_back('{16'h0001, 8'h5A});
        exp_q.push_back('{16'h0002, 8'hFF});
        start_dl();
        strobe(25'h0, 8'hA5);
        tick();
        strobe(25'h1, 8'h5A);
        tick();
        check("wait_after_2", {31'b0, ioctl_wait}, 1);
        strobe(25'h2, 8'hFF);
        wait_drain(3000);
        ioctl_download = 1'b0;
        wait_done(20);
        check("stream_sum", {16'b0, load_sum}, {16'b0, ck(16'h01FE)});
        check("stream_len", {16'b0, load_len}, {16'b0, ck(16'd3)});
        check("stream_err", {31'b0, load_err}, 0);

        // Overrun: five back-to-back strobes, only four fit
        do_reset();
        push_clear(2048);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{16'h0010 + 16'(i), 8'h11 + 8'(i)});
        end
        start_dl();
        for (int i = 0; i < 5; i++) begin
            strobe(25'h10 + 25'(i), 8'h11 + 8'(i));
        end
        tick();
        check("overrun_err", {31'b0, load_err}, 1);
        wait_drain(3000);
        ioctl_download = 1'b0;
        wait_done(20);
        check("overrun_len", {16'b0, load_len}, {16'b0, ck(16'd4)});

        // Latency, then range / cosmo vector table
        do_reset();
        push_clear(2048);
        start_dl();
        wait_drain(3000);
        begin
            logic [15:0] sum;
            logic [15:0] len;
            exp_q.push_back('{16'h2000, 8'h3C});
            sum = 16'h003C;
            len = 16'd1;
            strobe(25'h2000, 8'h3C);
            check("lat_n_wr", {31'b0, dn_wr}, 0);
            tick();
            check("lat_n1_wr", {31'b0, dn_wr}, 1);
            check("lat_addr", {16'b0, dn_addr}, 32'h2000);
            check("lat_data", {24'b0, dn_data}, 32'h3C);
            tick();
            check("lat_single", {31'b0, dn_wr}, 0);
            for (int i = 0; i < 6; i++) begin
                mod_cosmo = vt[i].cosmo;
                if (vt[i].wr) begin
                    exp_q.push_back('{vt[i].addr[15:0], vt[i].data});
                    sum = sum + {8'h00, vt[i].data};
                    len = len + 16'd1;
                end
                strobe(vt[i].addr, vt[i].data);
                repeat (3) tick();
                check($sformatf("vec%0d_err", i), {31'b0, load_err},
                      {31'b0, vt[i].err});
                check($sformatf("vec%0d_q", i), exp_q.size(), 0);
            end
            mod_cosmo = 1'b0;
            ioctl_download = 1'b0;
            wait_done(20);
            check("vec_sum", {16'b0, load_sum}, {16'b0, ck(sum)});
            check("vec_len", {16'b0, load_len}, {16'b0, ck(len)});
        end

        // Reset in the middle of the fill, then restart
        do_reset();
        push_clear(100);
        start_dl();
        repeat (100) tick();
        @(negedge clk);
        #1;
        check("mid_q", exp_q.size(), 0);
        Reset_n = 1'b0;
        #1;
        check("mid_rst_wr", {31'b0, dn_wr}, 0);
        check("mid_rst_addr", {16'b0, dn_addr}, 0);
        check("mid_rst_busy", {31'b0, load_busy}, 0);
        ioctl_download = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
        push_clear(2048);
        start_dl();
        wait_drain(3000);
        ioctl_download = 1'b0;
        wait_done(20);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
